rf_read_arbiter: RTL and testbench

- Shares the single register-file read port (5-bit selector into the 32-to-1 read mux, 32-bit mux output) among NREQ requesters.
- Round-robin grant, valid/ready handshake on both sides.
- Two-stage pipeline giving one read per cycle and fixed 2-cycle latency.
- Sits between the processor's read clients (decode, debug, etc.) and the register-file read mux.

---
 rtl/rf_read_arbiter.sv | 113 +++++++++++
 tb/tb_rf_read_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port across NREQ clients, 2-cycle fixed latency.
// Optional same-cycle write forwarding into the response is enabled by defining RF_ARB_FWD_EN.
module rf_read_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      rd_sel,
  input  logic [DW-1:0]      rd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [AW-1:0]      rsp_addr,
  output logic [DW-1:0]      rsp_data,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data
);

  // Handshake: a transfer happens on a cycle where valid & ready are both high; a
  // requester keeps valid and address stable until accepted, ready never depends on a drop.
  logic           s1_valid;
  logic [AW-1:0]  sel_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] last_g;
  logic [IDW-1:0] winner;
  logic [IDW:0]   cand;
  logic           found;
  logic           adv1;
  logic           adv2;
  logic           accept;
  logic [DW-1:0]  cap_data;
  logic [AW-1:0]  addr_arr [NREQ];

  assign adv2   = !rsp_valid || rsp_ready;
  assign adv1   = !s1_valid || adv2;
  assign rd_sel = sel_q;
  assign accept = found && adv1 && rst_n;

  always_comb begin
    for (int i = 0; i < NREQ; i++) addr_arr[i] = req_addr[i*AW +: AW];
  end

  // Search starts just after the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = last_g;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_g} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

`ifdef RF_ARB_FWD_EN
  assign cap_data = (wr_en && (wr_addr == sel_q)) ? wr_data : rd_data;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign cap_data  = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      sel_q     <= '0;
      id_q      <= '0;
      last_g    <= IDW'(NREQ-1);
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      if (adv1) begin
        if (accept) begin
          s1_valid <= 1'b1;
          sel_q    <= addr_arr[winner];
          id_q     <= winner;
          last_g   <= winner;
        end else begin
          s1_valid <= 1'b0;
        end
      end
      // S2 only loads when it can advance, so a held response is never overwritten.
      if (adv2) begin
        if (s1_valid) begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_addr  <= sel_q;
          rsp_data  <= cap_data;
        end else begin
          rsp_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: directed scenarios plus random traffic checked against a
// queue-based model of the read pipeline (capacity 2, latency 2, round-robin grants).
module tb_rf_read_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IDW  = 2;
  localparam int EW   = 32 + IDW + AW + DW;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      rd_sel;
  logic [DW-1:0]      rd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [AW-1:0]      rsp_addr;
  logic [DW-1:0]      rsp_data;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;

  // clock / reset
  always #5 clk = ~clk;

  logic [DW-1:0] regfile [32];
  assign rd_data = regfile[rd_sel];

  rf_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // scoreboard: {accept_cycle, id, addr, data}
  logic [EW-1:0]   exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              m_last;
  logic [AW-1:0]   m_sel;
  logic [NREQ-1:0] pending;
  logic [AW-1:0]   paddr [NREQ];
  bit              refill;
  bit              ovr_en;
  logic [DW-1:0]   ovr_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last = NREQ - 1;
    m_sel  = '0;
  endtask

  task automatic drive_reqs();
    req_valid = pending;
    for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = paddr[i];
  endtask

  // One clock: drive, check against the model, advance the model, move to next negedge.
  task automatic step();
    logic [EW-1:0]   head;
    logic [NREQ-1:0] exp_ready;
    logic [DW-1:0]   d;
    bit              present;
    bit              allowed;
    bit              found;
    int              w;
    drive_reqs();
    #1;
    present = (exp_q.size() > 0) && (cyc >= int'(exp_q[0][EW-1 -: 32]) + 2);
    allowed = !((exp_q.size() >= 2) && present && !rsp_ready);
    found = 1'b0;
    w = 0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_last + k) % NREQ;
      if (!found && pending[c]) begin
        found = 1'b1;
        w = c;
      end
    end
    exp_ready = '0;
    if (found && allowed) exp_ready[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(present));
    check("rd_sel", 64'(rd_sel), 64'(m_sel));
    if (present) begin
      head = exp_q[0];
      check("rsp_id", 64'(rsp_id), 64'(head[DW+AW +: IDW]));
      check("rsp_addr", 64'(rsp_addr), 64'(head[DW +: AW]));
      check("rsp_data", 64'(rsp_data), 64'(head[DW-1:0]));
      if (rsp_ready) void'(exp_q.pop_front());
    end
    if (found && allowed) begin
      d = ovr_en ? ovr_data : regfile[paddr[w]];
      ovr_en = 1'b0;
      exp_q.push_back({32'(cyc), IDW'(w), paddr[w], d});
      m_last = w;
      m_sel  = paddr[w];
      if (!refill) pending[w] = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    drive_reqs();
    repeat (n) begin
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rd_sel", 64'(rd_sel), 64'd0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (pending != '0 || exp_q.size() != 0); i++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_addr = '0;
    rsp_ready = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    refill = 1'b0;
    ovr_en = 1'b0;
    ovr_data = '0;
    pending = '0;
    for (int i = 0; i < NREQ; i++) paddr[i] = '0;
    for (int r = 0; r < 32; r++) regfile[r] = $urandom;
    regfile[7] = 32'hDEADBEEF;
    regfile[9] = 32'h1;
    model_reset();
    @(negedge clk);

    // reset with every requester asking; first grant must go to requester 0
    pending = '1;
    do_reset(2);
    drive_reqs();
    #1;
    check("first_grant", 64'(req_ready), 64'h1);
    step();
    drain();

    // single read of r7 from requester 1
    paddr[1] = 5'd7;
    pending = 4'b0010;
    drain();

    // round-robin with continuous requests
    for (int i = 0; i < NREQ; i++) paddr[i] = AW'(i + 1);
    pending = '1;
    refill = 1'b1;
    repeat (12) step();
    refill = 1'b0;
    drain();

    // backpressure with both stages full
    pending = '1;
    refill = 1'b1;
    step();
    rsp_ready = 1'b0;
    repeat (6) step();
    rsp_ready = 1'b1;
    refill = 1'b0;
    drain();

    // write forwarding at capture, then a write to the held register in S2
    paddr[2] = 5'd9;
    pending = 4'b0100;
    ovr_en = 1'b1;
`ifdef RF_ARB_FWD_EN
    ovr_data = 32'h55;
`else
    ovr_data = 32'h1;
`endif
    step();
    wr_en = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h55;
    rsp_ready = 1'b0;
    step();
    wr_data = 32'h77;
    step();
    wr_en = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // reset while S1 and S2 both hold a read
    pending = '1;
    refill = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    step();
    do_reset(1);
    rsp_ready = 1'b1;
    step();
    step();
    refill = 1'b0;
    drain();

    // random traffic
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          paddr[i] = AW'($urandom_range(0, 31));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
